// File: rtl/uart_rx_ctrl_if.sv
// Consumer-side bundle for the UART receive sequencer: received byte,
// its valid/ack handshake and the per-frame status pulses.
interface uart_rx_ctrl_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ack;
  logic                 frame_err;
  logic                 overrun;
  logic                 busy;

  // Receiver side: produces the byte and status, consumes the read strobe.
  modport master (
    output rx_data,
    output rx_valid,
    output frame_err,
    output overrun,
    output busy,
    input  rx_ack
  );

  // Consumer side: reads the byte and status, issues the read strobe.
  modport slave (
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  overrun,
    input  busy,
    output rx_ack
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer. Watches rxd for a start edge, enables the external
// baud tick generator, samples one bit per mid-bit tick (LSB first), checks
// the stop bit and hands the byte to the consumer through valid/ack.
module uart_rx_ctrl #(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           RSTn,
  input  logic           rxd,
  input  logic           bps_tick,
  output logic           bps_en,
  uart_rx_ctrl_if.master rx_if
);

  localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q, ferr_d;
  logic                   ovr_q, ovr_d;

  logic                   rxd_s;
  logic                   fall_edge;
  logic                   valid_after_ack;
  logic [DATA_BITS:0]     shift_ext;

  assign rxd_s     = sync_q[SYNC_STAGES-1];
  assign fall_edge = prev_q & ~rxd_s;
  // Bits arrive LSB first, so each new bit enters at the top and moves down.
  assign shift_ext = {rxd_s, shift_q};

  // Next-state, datapath and handshake logic.
  always_comb begin
    state_d         = state_q;
    sync_d          = {sync_q[SYNC_STAGES-2:0], rxd};
    prev_d          = rxd_s;
    cnt_d           = cnt_q;
    shift_d         = shift_q;
    data_d          = data_q;
    // An ack in the same cycle as a good stop bit frees the holding register.
    valid_after_ack = valid_q & ~rx_if.rx_ack;
    valid_d         = valid_after_ack;
    ferr_d          = 1'b0;
    ovr_d           = 1'b0;

    case (state_q)
      IDLE: begin
        // The edge needs a high prev sample, so a held-low break cannot restart us.
        if (fall_edge) state_d = START;
      end
      START: begin
        if (bps_tick) begin
          if (rxd_s) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            cnt_d   = '0;
          end
        end
      end
      DATA: begin
        if (bps_tick) begin
          shift_d = shift_ext[DATA_BITS:1];
          if (cnt_q == LAST_BIT) state_d = STOP;
          else                   cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (bps_tick) begin
          state_d = IDLE;
          if (!rxd_s) begin
            ferr_d = 1'b1;
          end else if (valid_after_ack) begin
            ovr_d = 1'b1;
          end else begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!RSTn) begin
      state_q <= IDLE;
      sync_q  <= '1;
      prev_q  <= 1'b1;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bps_en          = (state_q != IDLE);
  assign rx_if.busy      = (state_q != IDLE);
  assign rx_if.rx_data   = data_q;
  assign rx_if.rx_valid  = valid_q;
  assign rx_if.frame_err = ferr_q;
  assign rx_if.overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: a 16-clk/bit tick generator driven by bps_en, a
// frame-level reference model fed by the stimulus, and a per-cycle compare.
module tb_uart_rx_ctrl;
  localparam int DB  = 8;
  localparam int BPS = 16;

  logic clk      = 1'b0;
  logic RSTn     = 1'b0;
  logic rxd      = 1'b1;
  logic bps_tick = 1'b0;
  logic bps_en;
  logic [4:0] bcnt = '0;

  uart_rx_ctrl_if #(.DATA_BITS(DB)) rx_if ();

  uart_rx_ctrl #(.DATA_BITS(DB), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .RSTn     (RSTn),
    .rxd      (rxd),
    .bps_tick (bps_tick),
    .bps_en   (bps_en),
    .rx_if    (rx_if)
  );

  always #5 clk = ~clk;

  // Baud tick generator: counter held clear while disabled, pulse at mid-bit.
  always @(posedge clk) begin
    if (!bps_en) begin
      bcnt     <= '0;
      bps_tick <= 1'b0;
    end else begin
      bcnt     <= (bcnt == 5'(BPS - 1)) ? 5'd0 : bcnt + 5'd1;
      bps_tick <= (bcnt == 5'(BPS / 2 - 1));
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Frames the line carries, in order; the model retires each one on its last tick.
  typedef struct packed {
    logic       fs;    // false start: only the start-bit tick happens
    logic       stop;  // stop bit level
    logic [7:0] d;
  } frame_t;

  frame_t     pend[$];
  int         m_ticks;
  logic       m_valid, m_ferr, m_ovr;
  logic [7:0] m_data;

  // Reference model: a frame ends on its 1st (false start) or 10th tick.
  always @(posedge clk) begin : model
    logic   v_after;
    frame_t fr;
    int     need;
    if (!RSTn) begin
      m_valid <= 1'b0; m_data <= '0; m_ferr <= 1'b0; m_ovr <= 1'b0;
      m_ticks <= 0;
      pend.delete();
    end else begin
      v_after = m_valid & ~rx_if.rx_ack;
      m_ferr  <= 1'b0;
      m_ovr   <= 1'b0;
      m_valid <= v_after;
      if (bps_tick && pend.size() > 0) begin
        need = pend[0].fs ? 1 : DB + 2;
        if (m_ticks + 1 == need) begin
          fr = pend.pop_front();
          m_ticks <= 0;
          if (!fr.fs) begin
            if (!fr.stop)     m_ferr <= 1'b1;
            else if (v_after) m_ovr  <= 1'b1;
            else begin
              m_data  <= fr.d;
              m_valid <= 1'b1;
            end
          end
        end else begin
          m_ticks <= m_ticks + 1;
        end
      end
    end
  end

  bit chk_en = 0;
  int ferr_cnt = 0, ovr_cnt = 0, en_cnt = 0;

  // Per-cycle comparison of DUT outputs against the model, away from the edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("rx_valid",  32'(rx_if.rx_valid),  32'(m_valid));
      check("rx_data",   32'(rx_if.rx_data),   32'(m_data));
      check("frame_err", 32'(rx_if.frame_err), 32'(m_ferr));
      check("overrun",   32'(rx_if.overrun),   32'(m_ovr));
      check("busy",      32'(rx_if.busy),      32'(bps_en));
      if (rx_if.frame_err) ferr_cnt++;
      if (rx_if.overrun)   ovr_cnt++;
      if (bps_en)          en_cnt++;
    end
  end

  bit ack_req = 0, ack_on_stop = 0, rand_ack = 0;

  // Sole driver of rx_ack: manual pulses, ack aligned with a stop tick, random acks.
  always @(negedge clk) begin : ack_drv
    logic a;
    a = 1'b0;
    if (ack_req) begin a = 1'b1; ack_req = 0; end
    if (ack_on_stop && bps_tick && pend.size() > 0 && !pend[0].fs && m_ticks == DB + 1) begin
      a = 1'b1;
      ack_on_stop = 0;
    end
    if (rand_ack && $urandom_range(0, 5) == 0) a = 1'b1;
    rx_if.rx_ack = a;
  end

  task automatic send_frame(input logic [7:0] d, input logic stop, input int gap, input bit brk);
    frame_t f;
    f.fs = 1'b0; f.stop = stop; f.d = d;
    pend.push_back(f);
    rxd = 1'b0;
    repeat (BPS) @(negedge clk);
    for (int i = 0; i < DB; i++) begin
      rxd = d[i];
      repeat (BPS) @(negedge clk);
    end
    rxd = stop;
    repeat (BPS) @(negedge clk);
    if (!brk) rxd = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic false_start(input int low_clks);
    frame_t f;
    f.fs = 1'b1; f.stop = 1'b1; f.d = '0;
    pend.push_back(f);
    rxd = 1'b0;
    repeat (low_clks) @(negedge clk);
    rxd = 1'b1;
    repeat (30) @(negedge clk);
  endtask

  task automatic pulse_ack();
    @(posedge clk);
    ack_req = 1;
    repeat (3) @(negedge clk);
  endtask

  initial begin : main
    int en_mark;
    logic [7:0] d;
    logic       stop;
    rx_if.rx_ack = 1'b0;
    RSTn = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_bps_en",   32'(bps_en),         32'd0);
    check("reset_rx_valid", 32'(rx_if.rx_valid), 32'd0);
    check("reset_busy",     32'(rx_if.busy),     32'd0);
    check("reset_rx_data",  32'(rx_if.rx_data),  32'd0);
    RSTn   = 1'b1;
    chk_en = 1;

    // Idle line: nothing may start.
    repeat (100) @(negedge clk);
    check("idle_no_en", 32'(en_cnt), 32'd0);

    // Single good frame, then read it out.
    send_frame(8'hA5, 1'b1, 4, 0);
    check("a5_data",    32'(rx_if.rx_data),  32'hA5);
    check("a5_model",   32'(m_data),         32'hA5);
    check("a5_valid",   32'(rx_if.rx_valid), 32'd1);
    check("a5_bps_en",  32'(bps_en),         32'd0);
    pulse_ack();
    check("a5_acked",   32'(rx_if.rx_valid), 32'd0);

    // Glitch shorter than a bit: rejected at the start-bit tick.
    false_start(4);
    check("fs_valid", 32'(rx_if.rx_valid), 32'd0);
    check("fs_ferr",  32'(ferr_cnt),       32'd0);
    check("fs_idle",  32'(bps_en),         32'd0);

    // Bad stop bit, line then held low as a break.
    send_frame(8'h3C, 1'b0, 2, 1);
    en_mark = en_cnt;
    repeat (40) @(negedge clk);
    check("ferr_count", 32'(ferr_cnt),       32'd1);
    check("ferr_valid", 32'(rx_if.rx_valid), 32'd0);
    check("ferr_data",  32'(rx_if.rx_data),  32'hA5);
    check("break_hold", 32'(en_cnt),         32'(en_mark));
    rxd = 1'b1;
    repeat (5) @(negedge clk);

    // Back-to-back frames without ack: second one is dropped.
    send_frame(8'h11, 1'b1, 0, 0);
    send_frame(8'h22, 1'b1, 4, 0);
    check("ovr_data",  32'(rx_if.rx_data),  32'h11);
    check("ovr_count", 32'(ovr_cnt),        32'd1);
    check("ovr_valid", 32'(rx_if.rx_valid), 32'd1);
    pulse_ack();

    // Same again, but ack lands on the second stop tick: new byte replaces old.
    send_frame(8'h11, 1'b1, 0, 0);
    @(posedge clk);
    ack_on_stop = 1;
    send_frame(8'h22, 1'b1, 4, 0);
    check("ackstop_data",  32'(rx_if.rx_data),  32'h22);
    check("ackstop_model", 32'(m_data),         32'h22);
    check("ackstop_valid", 32'(rx_if.rx_valid), 32'd1);
    check("ackstop_novr",  32'(ovr_cnt),        32'd1);
    pulse_ack();

    // Reset in the middle of a frame aborts it silently.
    fork
      send_frame(8'hFF, 1'b1, 4, 0);
      begin
        repeat (60) @(negedge clk);
        RSTn = 1'b0;
        @(negedge clk);
        RSTn = 1'b1;
        check("rst_bps_en", 32'(bps_en), 32'd0);
      end
    join
    check("rst_no_ferr", 32'(ferr_cnt),       32'd1);
    check("rst_no_ovr",  32'(ovr_cnt),        32'd1);
    check("rst_valid",   32'(rx_if.rx_valid), 32'd0);
    send_frame(8'h5A, 1'b1, 4, 0);
    check("post_rst_data", 32'(rx_if.rx_data), 32'h5A);
    pulse_ack();

    // Randomized traffic with random acks; the model checks every cycle.
    rand_ack = 1;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        false_start($urandom_range(1, 6));
      end else begin
        d    = 8'($urandom);
        stop = ($urandom_range(0, 4) != 0);
        send_frame(d, stop, stop ? $urandom_range(0, 20) : $urandom_range(3, 20), 0);
      end
    end
    rand_ack = 0;
    repeat (40) @(negedge clk);
    check("all_frames_retired", 32'(pend.size()), 32'd0);
    check("final_idle",         32'(bps_en),      32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
